store_buffer: RTL and testbench

- Word-granular store buffer between the MEM-stage store path and the data memory write port.
- Committed stores (sw) enter in order and drain one per cycle into data memory whenever the DM write port is not blocked.
- Loads issued in MEM look up the buffer. The youngest matching pending store supplies the data, so no stale DM word is returned.
- Also exposes an empty flag, used by halt/syscall logic to wait for all stores to reach memory.

---
 rtl/store_buffer.sv | 120 ++++++++++++
 tb/tb_store_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order word store buffer with youngest-match load forwarding.
// Optional SB_COALESCE_EN merges a store into the youngest entry with the same word address. Rev 1.0
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  input  logic             dm_block,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [31:0]      dm_pc,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   c_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_CNT1  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_PTR1  = PTR_W'(1);

  logic [29:0]      r_addr  [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_accept;
  logic w_alloc;
  logic w_coal;
  logic w_unused_bits;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == c_DEPTH);
  assign w_unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // Reset gates the strobe so pending stores cannot reach DM on the reset edge.
  assign dm_we    = !w_empty && !dm_block && !reset;
  assign dm_addr  = w_empty ? 32'h0 : {r_addr[r_head], 2'b00};
  assign dm_wdata = w_empty ? 32'h0 : r_data[r_head];
  assign dm_pc    = w_empty ? 32'h0 : r_pc[r_head];
  assign empty    = w_empty;
  assign count    = r_count;

`ifdef SB_COALESCE_EN
  logic [PTR_W-1:0] w_young;
  assign w_young  = r_tail - c_PTR1;
  // The head entry is leaving this edge, so merging into it would lose the store.
  assign w_coal   = !w_empty && (r_addr[w_young] == st_addr[31:2])
                    && !((w_young == r_head) && dm_we);
  assign st_ready = !w_full || w_coal;
`else
  assign w_coal   = 1'b0;
  assign st_ready = !w_full;
`endif

  assign w_accept = st_valid && st_ready;
  assign w_alloc  = w_accept && !w_coal;

  // Walk oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    ld_hit  = 1'b0;
    ld_data = 32'h0;
    w_idx   = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_valid[w_idx] && (r_addr[w_idx] == ld_addr[31:2])) begin
        ld_hit  = 1'b1;
        ld_data = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (dm_we) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + c_PTR1;
      end
      if (w_alloc) begin
        r_addr[r_tail]  <= st_addr[31:2];
        r_data[r_tail]  <= st_data;
        r_pc[r_tail]    <= st_pc;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + c_PTR1;
      end else if (w_accept) begin
        r_data[r_tail - c_PTR1] <= st_data;
        r_pc[r_tail - c_PTR1]   <= st_pc;
      end
      case ({w_alloc, dm_we})
        2'b10:   r_count <= r_count + c_CNT1;
        2'b01:   r_count <= r_count - c_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-based reference model checked every cycle, plus directed literal checks.
`default_nettype none

module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic             st_ready;
  logic [31:0]      st_addr, st_data, st_pc;
  logic             dm_block;
  logic             dm_we;
  logic [31:0]      dm_addr, dm_wdata, dm_pc;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic [31:0]      ld_data;
  logic             empty;
  logic [PTR_W:0]   count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .dm_block(dm_block), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .empty(empty), .count(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stores as a queue, oldest at index 0.
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t  q[$];
  bit    mdl_on = 1'b0;
  logic  e_ready, e_we, e_hit, e_coal;
  logic [31:0] e_addr, e_wdata, e_pc, e_ld;

  function automatic void calc();
    e_we    = (q.size() > 0) && !dm_block && !reset;
    e_coal  = 1'b0;
`ifdef SB_COALESCE_EN
    if (q.size() > 0)
      e_coal = (q[q.size()-1].a == st_addr[31:2]) && !(q.size() == 1 && e_we);
`endif
    e_ready = (q.size() < DEPTH) || e_coal;
    e_addr  = (q.size() > 0) ? {q[0].a, 2'b00} : 32'h0;
    e_wdata = (q.size() > 0) ? q[0].d : 32'h0;
    e_pc    = (q.size() > 0) ? q[0].p : 32'h0;
    e_hit   = 1'b0;
    e_ld    = 32'h0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!e_hit && q[i].a == ld_addr[31:2]) begin
        e_hit = 1'b1;
        e_ld  = q[i].d;
      end
    end
  endfunction

  always @(posedge clk) begin
    calc();
    if (reset) begin
      q.delete();
      mdl_on = 1'b1;
    end else begin
      if (e_we) void'(q.pop_front());
      if (st_valid && e_ready) begin
        if (e_coal) begin
          q[q.size()-1].d = st_data;
          q[q.size()-1].p = st_pc;
        end else begin
          q.push_back('{a: st_addr[31:2], d: st_data, p: st_pc});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      calc();
      chk("st_ready", 32'(st_ready), 32'(e_ready));
      chk("dm_we",    32'(dm_we),    32'(e_we));
      chk("dm_addr",  dm_addr,  e_addr);
      chk("dm_wdata", dm_wdata, e_wdata);
      chk("dm_pc",    dm_pc,    e_pc);
      chk("ld_hit",   32'(ld_hit),   32'(e_hit));
      chk("ld_data",  ld_data,  e_ld);
      chk("count",    32'(count),    32'(q.size()));
      chk("empty",    32'(empty),    32'(q.size() == 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_pc    = p;
    cyc();
    st_valid = 1'b0;
  endtask

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        blk;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs [10];

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    dm_block = 1'b0; ld_addr = '0;
    cyc(); cyc();
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b0;

    // Single store drains the cycle after acceptance.
    push(32'h10, 32'h12345678, 32'h3000);
    #1;
    chk("t1_we",    32'(dm_we), 32'd1);
    chk("t1_addr",  dm_addr,  32'h10);
    chk("t1_wdata", dm_wdata, 32'h12345678);
    chk("t1_pc",    dm_pc,    32'h3000);
    cyc(); #1;
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill while blocked, then drain in order.
    dm_block = 1'b1;
    for (int k = 0; k < 4; k++) push(32'(4*k), 32'hC0DE0000 + 32'(k), 32'h4000 + 32'(4*k));
    #1;
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_ready", 32'(st_ready), 32'd0);
    chk("t2_we",    32'(dm_we), 32'd0);
    dm_block = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_drain_we",   32'(dm_we), 32'd1);
      chk("t2_drain_addr", dm_addr, 32'(4*k));
      cyc();
    end

    // Two stores to one word: youngest forwards.
    dm_block = 1'b1;
    push(32'h20, 32'hAAAA0000, 32'h5000);
    push(32'h20, 32'hBBBB0000, 32'h5004);
    ld_addr = 32'h22; #1;
    chk("t3_hit",  32'(ld_hit), 32'd1);
    chk("t3_data", ld_data, 32'hBBBB0000);
`ifdef SB_COALESCE_EN
    chk("t3_count", 32'(count), 32'd1);
`else
    chk("t3_count", 32'(count), 32'd2);
`endif
    ld_addr = 32'h40; #1;
    chk("t6_hit",  32'(ld_hit), 32'd0);
    chk("t6_data", ld_data, 32'h0);

    // Full with a drain and a store offered in the same cycle.
    push(32'h30, 32'h30303030, 32'h5008);
    push(32'h34, 32'h34343434, 32'h500C);
    push(32'h38, 32'h38383838, 32'h5010);
    dm_block = 1'b0;
    st_valid = 1'b1; st_addr = 32'h50; st_data = 32'h50505050; st_pc = 32'h5014;
    #1;
    chk("t4_ready_full", 32'(st_ready), 32'd0);
    chk("t4_we_full",    32'(dm_we), 32'd1);
    cyc();
    st_valid = 1'b0; #1;
    chk("t4_count", 32'(count), 32'd3);
    chk("t4_ready", 32'(st_ready), 32'd1);
    cyc(); cyc(); cyc();

    // Reset with pending stores and a store offered in the reset cycle.
    dm_block = 1'b1;
    push(32'h60, 32'h60606060, 32'h6000);
    push(32'h64, 32'h64646464, 32'h6004);
    ld_addr  = 32'h64;
    reset    = 1'b1;
    dm_block = 1'b0;
    st_valid = 1'b1; st_addr = 32'h70; st_data = 32'h70707070; st_pc = 32'h6008;
    #1;
    chk("t5_we_in_reset", 32'(dm_we), 32'd0);
    cyc();
    reset = 1'b0; st_valid = 1'b0; #1;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_we",    32'(dm_we), 32'd0);
    chk("t5_hit",   32'(ld_hit), 32'd0);

    // Mixed traffic: loads hitting a draining head, blocked bursts, same-word stores.
    vecs[0] = '{v:1'b1, a:32'h100, d:32'h11, blk:1'b1, ld:32'h0};
    vecs[1] = '{v:1'b1, a:32'h104, d:32'h22, blk:1'b1, ld:32'h100};
    vecs[2] = '{v:1'b1, a:32'h104, d:32'h33, blk:1'b1, ld:32'h104};
    vecs[3] = '{v:1'b0, a:32'h0,   d:32'h0,  blk:1'b0, ld:32'h100};
    vecs[4] = '{v:1'b1, a:32'h104, d:32'h44, blk:1'b0, ld:32'h104};
    vecs[5] = '{v:1'b0, a:32'h0,   d:32'h0,  blk:1'b0, ld:32'h105};
    vecs[6] = '{v:1'b1, a:32'h108, d:32'h55, blk:1'b0, ld:32'h108};
    vecs[7] = '{v:1'b1, a:32'h108, d:32'h66, blk:1'b0, ld:32'h108};
    vecs[8] = '{v:1'b0, a:32'h0,   d:32'h0,  blk:1'b0, ld:32'h108};
    vecs[9] = '{v:1'b0, a:32'h0,   d:32'h0,  blk:1'b0, ld:32'h0};
    for (int k = 0; k < 10; k++) begin
      st_valid = vecs[k].v; st_addr = vecs[k].a; st_data = vecs[k].d;
      st_pc = 32'h7000 + 32'(4*k);
      dm_block = vecs[k].blk; ld_addr = vecs[k].ld;
      cyc();
    end
    st_valid = 1'b0;
    repeat (6) cyc();
    #1;
    chk("end_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
